// File: rtl/cnt_pkg.sv
// Shared constants and the load-clamp helper for the up/down modulus counter family.
// The clamp works at the widest supported counter width so any instance can use it.
package cnt_pkg;

    localparam logic CNT_UP    = 1'b1;
    localparam logic CNT_DOWN  = 1'b0;
    localparam int   CNT_MAX_W = 16;

    // Out-of-range load data is pinned to the last legal state, never left illegal.
    function automatic logic [CNT_MAX_W:0] cnt_clamp(
        input logic [CNT_MAX_W:0] d,
        input logic [CNT_MAX_W:0] modulus
    );
        return (d >= modulus) ? (modulus - 17'd1) : d;
    endfunction

endpackage

// File: rtl/tc_detect.sv
// Terminal-value compare: combinational TC for cascading and the wrap strobe for this stage.
// Zero latency; TC is forced low while the asynchronous clear is held.
module tc_detect
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_ud,
    input  logic             i_cet,
    input  logic             i_cep,
    input  logic             i_clr,
    output logic             o_tc,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

    logic w_at_term;

    assign w_at_term = (i_ud == CNT_UP) ? (i_q == QMAX) : (i_q == '0);
    assign o_tc      = i_cet & ~i_clr & w_at_term;
    // A wrap happens only when both enables are up at the terminal value.
    assign o_wrap    = i_cep & o_tc;

endmodule

// File: rtl/updown_mod_counter.sv
// Presettable up/down counter with programmable modulus and CEP/CET/TC cascade; one edge to update Q.
// Optional sticky wrap flag OVF when CNT_OVF_FLAG_EN is defined. No backpressure: load > count > hold.
module updown_mod_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             CP,
    input  logic             CR,
    input  logic             PE,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC
`ifdef CNT_OVF_FLAG_EN
    ,
    output logic             OVF
`endif
);

    localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_load;
    logic             w_count_en;
    logic             w_wrap;

    tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .i_q    (r_q),
        .i_ud   (UD),
        .i_cet  (CET),
        .i_cep  (CEP),
        .i_clr  (CR),
        .o_tc   (TC),
        .o_wrap (w_wrap)
    );

    assign w_load     = WIDTH'(cnt_clamp(17'(D), 17'(MODULUS)));
    assign w_count_en = CEP & CET;

    always_comb begin
        w_q_next = r_q;
        if (!PE) begin
            w_q_next = w_load;
        end else if (w_count_en) begin
            // Wrap by compare so non-power-of-two moduli never leave 0..MODULUS-1.
            if (w_wrap) begin
                w_q_next = (UD == CNT_DOWN) ? QMAX : '0;
            end else if (UD == CNT_UP) begin
                w_q_next = r_q + WIDTH'(1);
            end else begin
                w_q_next = r_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign Q = r_q;

`ifdef CNT_OVF_FLAG_EN
    logic r_ovf;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            r_ovf <= 1'b0;
        end else if (!PE) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end
    end

    assign OVF = r_ovf;
`endif

endmodule
